// File: rtl/alu_result_splitter.sv
// ALU result return path: captures a wide ALU result and streams it
// to the UART transmitter one frame at a time, least-significant first.
module alu_result_splitter #(
   parameter int Input_data_width  = 16,
   parameter int Output_data_width = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [Input_data_width-1:0]  ALU_OUT,
   input  logic                         OUT_VALID,
   input  logic                         TX_Busy,
   output logic [Output_data_width-1:0] TX_P_Data,
   output logic                         TX_Data_Valid,
   output logic                         Busy,
   output logic                         Overrun
);

   localparam int NBYTES = Input_data_width / Output_data_width;
   localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t                         state_q, state_d;
   logic [Input_data_width-1:0]    shift_q, shift_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [Output_data_width-1:0]   txd_q, txd_d;
   logic                           txv_q, txv_d;
   logic                           busy_q, busy_d;
   logic                           ovr_q, ovr_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         txd_q   <= '0;
         txv_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
         txv_q   <= txv_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (OUT_VALID) begin
               shift_d = ALU_OUT;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (!TX_Busy) state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (TX_Busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!TX_Busy) begin
               shift_d = shift_q >> Output_data_width;
               // counter saturates on the last frame; cleared on capture
               if (cnt_q == LAST) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      txd_d  = txd_q;
      txv_d  = 1'b0;
      busy_d = (state_d != IDLE);
      ovr_d  = OUT_VALID && (state_q != IDLE);
      if (state_q == SEND && !TX_Busy) begin
         txd_d = shift_q[Output_data_width-1:0];
         txv_d = 1'b1;
      end
   end

   assign TX_P_Data     = txd_q;
   assign TX_Data_Valid = txv_q;
   assign Busy          = busy_q;
   assign Overrun       = ovr_q;

endmodule
